// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Converts requested target words into J/K excitation commands for a bank
//   of WIDTH master-slave JK flip-flops. It keeps an internal model of the
//   bank's present value and issues J/K only for bits that must change. It
//   holds the commands for SETTLE_CYC cycles, then spends one CHECK cycle
//   before it accepts the next target.
//
//   Optional feature macro: JKX_FB_CHECK_EN
//     defined   : CHECK compares q_fb to the model; a mismatch sets sticky err.
//     undefined : q_fb is ignored and err stays 0. Timing is identical.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   tgt_valid  in   target word offered
//   tgt_data   in   [WIDTH] requested bank value
//   tgt_ready  out  high only in IDLE
//   j, k       out  [WIDTH] registered J/K commands (k all-ones clears bank in CLR)
//   q_fb       in   [WIDTH] bank Q feedback, sampled in CHECK
//   done       out  one-cycle pulse in CHECK
//   err        out  sticky feedback-mismatch flag

// Per-bit excitation: only move bits that differ. Don't-cares resolve to 0,
// so J=K=1 (toggle) is never produced.
module jk_excite_lane (
  input  logic m_i,
  input  logic t_i,
  output logic j_o,
  output logic k_o
);
  assign j_o = ~m_i &  t_i;
  assign k_o =  m_i & ~t_i;
endmodule

module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {S_CLR, S_IDLE, S_DRIVE, S_CHECK} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] model_q, tgt_q, j_q, k_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, err_q, rdy_q;

  logic [WIDTH-1:0] exc_j_d, exc_k_d;
  logic             mismatch_d;

  // Excitation is computed straight from the offered word so it can be
  // registered on the accept edge.
  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    jk_excite_lane u_lane (
      .m_i (model_q[b]),
      .t_i (tgt_data[b]),
      .j_o (exc_j_d[b]),
      .k_o (exc_k_d[b])
    );
  end

`ifdef JKX_FB_CHECK_EN
  assign mismatch_d = (q_fb != model_q);
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign mismatch_d  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLR;
      model_q <= '0;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '1;      // drive the whole bank to 0 while clearing
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLR: begin
          j_q     <= '0;
          k_q     <= '0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (tgt_valid && rdy_q) begin
            tgt_q   <= tgt_data;
            j_q     <= exc_j_d;
            k_q     <= exc_k_d;
            cnt_q   <= CW'(SETTLE_CYC - 1);
            rdy_q   <= 1'b0;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            j_q     <= '0;
            k_q     <= '0;
            model_q <= tgt_q;
            done_q  <= 1'b1;
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_CHECK: begin
          // model_q already holds the new target, and the bank has had the
          // settle window plus one cycle to move master->slave.
          if (mismatch_d) err_q <= 1'b1;
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_CLR;
      endcase
    end
  end

  assign tgt_ready = rdy_q;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         tgt_ready;
  logic [W-1:0] j, k;
  logic [W-1:0] q_fb;
  logic         done, err;

  int n_vec = 0;
  int n_err = 0;

  // reference state: what the bank should hold, and the sticky error flag
  logic [W-1:0] m_ref;
  logic         err_ref;

`ifdef JKX_FB_CHECK_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  jk_excitation_driver #(.WIDTH(W), .SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // J goes high where the bit must rise, K where it must fall.
  function automatic void exc_ref(input logic [W-1:0] m, input logic [W-1:0] t,
                                  output logic [W-1:0] ej, output logic [W-1:0] ek);
    for (int b = 0; b < W; b++) begin
      automatic int d = int'(t[b]) - int'(m[b]);
      ej[b] = (d == 1);
      ek[b] = (d == -1);
    end
  endfunction

  // Called at the negedge right after the accept edge; ends in the CHECK cycle.
  task automatic drive_phase(input logic [W-1:0] ej, input logic [W-1:0] ek);
    for (int i = 0; i < S; i++) begin
      chk("drv_j", 32'(j), 32'(ej));
      chk("drv_k", 32'(k), 32'(ek));
      chk("drv_no_toggle", 32'(j & k), 32'd0);
      chk("drv_rdy", 32'(tgt_ready), 32'd0);
      chk("drv_done", 32'(done), 32'd0);
      cyc();
    end
  endtask

  // Called in the CHECK cycle; ends in the following IDLE cycle.
  task automatic check_phase(input logic [W-1:0] t, input logic [W-1:0] qfb);
    chk("chk_done", 32'(done), 32'd1);
    chk("chk_jk", 32'({j, k}), 32'd0);
    chk("chk_rdy", 32'(tgt_ready), 32'd0);
    cyc();
    if (FB_EN && (qfb != t)) err_ref = 1'b1;
    m_ref = t;
    chk("idle_rdy", 32'(tgt_ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'(err_ref));
  endtask

  task automatic do_update(input logic [W-1:0] t, input logic [W-1:0] qfb,
                           input logic [W-1:0] ej, input logic [W-1:0] ek);
    chk("pre_rdy", 32'(tgt_ready), 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = t;
    q_fb      = qfb;
    cyc();
    tgt_valid = 1'b0;
    tgt_data  = '0;
    drive_phase(ej, ek);
    check_phase(t, qfb);
  endtask

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [W-1:0] ej, ek, t, qfb;

    // hand-derived vectors, starting from a cleared bank
    tbl[0] = '{4'b0101, 4'b0101, 4'b0000};  // set bits
    tbl[1] = '{4'b0011, 4'b0010, 4'b0100};  // mixed update
    tbl[2] = '{4'b0011, 4'b0000, 4'b0000};  // target equals model
    tbl[3] = '{4'b1100, 4'b1100, 4'b0011};
    tbl[4] = '{4'b0000, 4'b0000, 4'b1100};
    tbl[5] = '{4'b1111, 4'b1111, 4'b0000};

    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; q_fb = '0;
    m_ref = '0; err_ref = 1'b0;

    // reset exit
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_k", 32'(k), 32'hF);
    chk("rst_j", 32'(j), 32'h0);
    chk("rst_rdy", 32'(tgt_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cyc();                                   // first edge low: CLR -> IDLE
    chk("clr_exit_k", 32'(k), 32'h0);
    chk("clr_exit_rdy", 32'(tgt_ready), 32'd1);

    // table-driven updates with matching feedback
    for (int i = 0; i < 6; i++) begin
      do_update(tbl[i].tgt, tbl[i].tgt, tbl[i].ej, tbl[i].ek);
    end

    // mismatch: model 0000 -> 0101 while feedback stays 0000
    do_update(4'b0000, 4'b0000, 4'b0000, 4'b1111);
    do_update(4'b0101, 4'b0000, 4'b0101, 4'b0000);
    chk("mismatch_err", 32'(err), 32'(FB_EN));
    do_update(4'b1010, 4'b1010, 4'b1010, 4'b0101);
    chk("err_sticky", 32'(err), 32'(FB_EN));
    do_update(4'b0101, 4'b0101, 4'b0101, 4'b1010);

    // busy offer: 1111 held during a no-change update is taken on the next IDLE
    tgt_valid = 1'b1; tgt_data = 4'b0101; q_fb = 4'b0101;
    cyc();
    tgt_data = 4'b1111;
    drive_phase(4'b0000, 4'b0000);
    check_phase(4'b0101, 4'b0101);
    q_fb = 4'b1111;
    cyc();                                   // offer accepted on this edge
    tgt_valid = 1'b0;
    drive_phase(4'b1010, 4'b0000);
    check_phase(4'b1111, 4'b1111);

    // reset mid-DRIVE from model 1111
    do_update(4'b0011, 4'b0011, 4'b0000, 4'b1100);
    tgt_valid = 1'b1; tgt_data = 4'b1100; q_fb = 4'b1100;
    cyc();
    tgt_valid = 1'b0;
    chk("mid_drv_j", 32'(j), 32'hC);
    rst = 1'b1;
    cyc();
    chk("mid_rst_k", 32'(k), 32'hF);
    chk("mid_rst_j", 32'(j), 32'h0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rdy", 32'(tgt_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_done2", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    m_ref = '0; err_ref = 1'b0;
    do_update(4'b0110, 4'b0110, 4'b0110, 4'b0000);   // model restarted at 0

    // randomized updates against the reference model
    for (int i = 0; i < 40; i++) begin
      t   = W'($urandom);
      qfb = ($urandom_range(0, 4) == 0) ? W'($urandom) : t;
      exc_ref(m_ref, t, ej, ek);
      do_update(t, qfb, ej, ek);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
